fb_oled_reader: RTL

- Reads the camera frame buffer (4-4-4 RGB words) and supplies pixels to the SSD1351 OLED driver on its next_pixel requests.
- Crops, offsets and power-of-two decimates the image into a C_OUT_COLS x C_OUT_ROWS window.
- Packs each pixel to RGB332 or RGB565.
- Replaces the ad-hoc next_pixel colour register in the camera top; sits on the frame buffer read port.

---
 rtl/fb_oled_reader_pkg.sv | 56 +++++
 rtl/fb_oled_reader_if.sv | 48 ++++
 rtl/fb_oled_reader_fb_addr_gen.sv | 109 ++++++++++
 rtl/fb_oled_reader.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/fb_oled_reader_pkg.sv
// -----------------------------------------------------------------------------
// fb_oled_reader_pkg
// Shared definitions for the frame-buffer-to-OLED pixel reader:
//   - frame buffer word layout (4-4-4 RGB, red in the MSBs)
//   - RGB332 / RGB565 field widths
//   - reader FSM state encoding
//   - pack_pixel(): 4-4-4 buffer word to RGB332 (8 bit) or RGB565 (16 bit)
//   - bar_pixel():  4-4-4 word of one full-scale colour bar
// -----------------------------------------------------------------------------
package fb_oled_reader_pkg;

   // Frame buffer word layout
   localparam int C_NB_BUF_RED_DEF   = 4;
   localparam int C_NB_BUF_GREEN_DEF = 4;
   localparam int C_NB_BUF_BLUE_DEF  = 4;
   localparam int C_NB_BUF           = C_NB_BUF_RED_DEF + C_NB_BUF_GREEN_DEF + C_NB_BUF_BLUE_DEF;

   // Output colour formats
   localparam int C_RGB332_R = 3;
   localparam int C_RGB332_G = 3;
   localparam int C_RGB332_B = 2;
   localparam int C_RGB565_R = 5;
   localparam int C_RGB565_G = 6;
   localparam int C_RGB565_B = 5;

   typedef logic [C_NB_BUF-1:0] buf_word_t;

   typedef enum logic [1:0] {
      ST_PRIME = 2'd0,
      ST_FETCH = 2'd1,
      ST_LATCH = 2'd2,
      ST_READY = 2'd3
   } state_t;

   // Wider formats are filled by replicating channel MSBs so full scale
   // stays full scale.
   function automatic logic [15:0] pack_pixel(input buf_word_t w, input int color_bits);
      logic [3:0] r;
      logic [3:0] g;
      logic [3:0] b;
      r = w[11:8];
      g = w[7:4];
      b = w[3:0];
      if (color_bits == 16) begin
         pack_pixel = {r, r[3], g, g[3:2], b, b[3]};
      end else begin
         pack_pixel = {8'h00, r[3:1], g[3:1], b[3:2]};
      end
   endfunction

   // Bar index bits map directly to R/G/B enables: 0 black .. 7 white.
   function automatic buf_word_t bar_pixel(input logic [2:0] idx);
      bar_pixel = {{4{idx[2]}}, {4{idx[1]}}, {4{idx[0]}}};
   endfunction

endpackage

// File: rtl/fb_oled_reader_if.sv
// -----------------------------------------------------------------------------
// fb_oled_reader_if
// Bundles the OLED-driver handshake and frame buffer read port of the reader.
//   next_pixel  : driver request to advance one pixel
//   off_col/row : source window offsets (taken at frame start)
//   fb_addr     : frame buffer read address (reader output)
//   fb_pxl      : frame buffer read data, 1-cycle BRAM latency
//   color,x,y   : current packed pixel and its output coordinates
//   frame_start : one-cycle pulse on wrap to (0,0)
//   overrun     : sticky early-request flag
//   test_mode   : only with FB_OLED_READER_TEST_PATTERN_EN, selects colour bars
// Modports: master = driver/buffer side, slave = reader.
// -----------------------------------------------------------------------------
interface fb_oled_reader_if #(
   parameter int C_NB_IMG_PXLS = 15,
   parameter int C_BUF_W       = fb_oled_reader_pkg::C_NB_BUF,
   parameter int C_COLOR_BITS  = 8
);
   logic                     next_pixel;
   logic [7:0]               off_col;
   logic [7:0]               off_row;
   logic [C_NB_IMG_PXLS-1:0] fb_addr;
   logic [C_BUF_W-1:0]       fb_pxl;
   logic [C_COLOR_BITS-1:0]  color;
   logic [6:0]               x;
   logic [6:0]               y;
   logic                     frame_start;
   logic                     overrun;
`ifdef FB_OLED_READER_TEST_PATTERN_EN
   logic                     test_mode;
`endif

   modport master (
`ifdef FB_OLED_READER_TEST_PATTERN_EN
      output test_mode,
`endif
      output next_pixel, off_col, off_row, fb_pxl,
      input  fb_addr, color, x, y, frame_start, overrun
   );

   modport slave (
`ifdef FB_OLED_READER_TEST_PATTERN_EN
      input  test_mode,
`endif
      input  next_pixel, off_col, off_row, fb_pxl,
      output fb_addr, color, x, y, frame_start, overrun
   );
endinterface

// File: rtl/fb_oled_reader_fb_addr_gen.sv
// -----------------------------------------------------------------------------
// fb_oled_reader_fb_addr_gen
// Multiplier-free frame buffer address generator. Tracks the source position
// of the current output pixel with accumulators and registers fb_addr for it.
// Ports:
//   clk, rst               : clock, synchronous active-high reset
//   load_i                 : frame start; latch offsets, restart at (0,0)
//   step_col_i             : advance one output column
//   step_row_i             : advance to column 0 of the next output row
//   off_col_i, off_row_i   : source offsets, used on load_i only
//   fb_addr_o              : registered read address (held when out of image)
//   in_img_o               : registered in-image flag for the current pixel
// -----------------------------------------------------------------------------
module fb_oled_reader_fb_addr_gen #(
   parameter int C_IMG_COLS    = 160,
   parameter int C_IMG_ROWS    = 120,
   parameter int C_NB_IMG_PXLS = 15,
   parameter int C_SCALE_LOG2  = 0
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     load_i,
   input  logic                     step_col_i,
   input  logic                     step_row_i,
   input  logic [7:0]               off_col_i,
   input  logic [7:0]               off_row_i,
   output logic [C_NB_IMG_PXLS-1:0] fb_addr_o,
   output logic                     in_img_o
);

   // Accumulators get headroom so out-of-image positions never wrap back
   // into the image.
   localparam int AW = C_NB_IMG_PXLS + 4;
   localparam int CW = 11;
   localparam logic [AW-1:0] COL_STEP = AW'(1 << C_SCALE_LOG2);
   localparam logic [AW-1:0] ROW_STEP = AW'(C_IMG_COLS << C_SCALE_LOG2);
   localparam logic [CW-1:0] SRC_STEP = CW'(1 << C_SCALE_LOG2);

   logic [7:0]               off_col_q, off_col_d;
   logic [AW-1:0]            row_base_q, row_base_d;
   logic [AW-1:0]            col_addr_q, col_addr_d;
   logic [CW-1:0]            src_col_q, src_col_d;
   logic [CW-1:0]            src_row_q, src_row_d;
   logic [C_NB_IMG_PXLS-1:0] fb_addr_q, fb_addr_d;
   logic                     in_img_q, in_img_d;

   // off_row * C_IMG_COLS as shift-and-add over the constant's set bits.
   function automatic logic [AW-1:0] mul_img_cols(input logic [7:0] r);
      logic [AW-1:0] acc;
      acc = '0;
      for (int i = 0; i < AW; i++) begin
         if (((C_IMG_COLS >> i) & 1) != 0) begin
            acc = acc + (AW'(r) << i);
         end
      end
      return acc;
   endfunction

   always_comb begin
      off_col_d  = off_col_q;
      row_base_d = row_base_q;
      col_addr_d = col_addr_q;
      src_col_d  = src_col_q;
      src_row_d  = src_row_q;
      if (load_i) begin
         off_col_d  = off_col_i;
         row_base_d = mul_img_cols(off_row_i);
         col_addr_d = AW'(off_col_i);
         src_col_d  = CW'(off_col_i);
         src_row_d  = CW'(off_row_i);
      end else if (step_row_i) begin
         row_base_d = row_base_q + ROW_STEP;
         col_addr_d = AW'(off_col_q);
         src_col_d  = CW'(off_col_q);
         src_row_d  = src_row_q + SRC_STEP;
      end else if (step_col_i) begin
         col_addr_d = col_addr_q + COL_STEP;
         src_col_d  = src_col_q + SRC_STEP;
      end
      // Address is looked ahead from the next position so the BRAM read
      // is issued during FETCH.
      in_img_d  = (src_col_d < CW'(C_IMG_COLS)) && (src_row_d < CW'(C_IMG_ROWS));
      fb_addr_d = in_img_d ? C_NB_IMG_PXLS'(row_base_d + col_addr_d) : fb_addr_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         off_col_q  <= '0;
         row_base_q <= '0;
         col_addr_q <= '0;
         src_col_q  <= '0;
         src_row_q  <= '0;
         fb_addr_q  <= '0;
         in_img_q   <= 1'b0;
      end else begin
         off_col_q  <= off_col_d;
         row_base_q <= row_base_d;
         col_addr_q <= col_addr_d;
         src_col_q  <= src_col_d;
         src_row_q  <= src_row_d;
         fb_addr_q  <= fb_addr_d;
         in_img_q   <= in_img_d;
      end
   end

   assign fb_addr_o = fb_addr_q;
   assign in_img_o  = in_img_q;

endmodule

// File: rtl/fb_oled_reader.sv
// -----------------------------------------------------------------------------
// fb_oled_reader
// Reads the 4-4-4 camera frame buffer and serves packed pixels (RGB332 or
// RGB565) to the SSD1351 driver, cropping/offsetting/decimating the image
// into a C_OUT_COLS x C_OUT_ROWS window.
// Ports:
//   clk  : system clock
//   rst  : synchronous active-high reset
//   bus  : fb_oled_reader_if.slave (next_pixel, offsets, fb_addr/fb_pxl,
//          color, x, y, frame_start, overrun[, test_mode])
// Optional feature macro: FB_OLED_READER_TEST_PATTERN_EN adds test_mode,
// which replaces the pixel with 8 vertical colour bars chosen by x[6:4].
// Pixel pipeline: READY --next_pixel--> FETCH (address presented) -->
// LATCH (BRAM data valid, colour registered) --> READY.
// -----------------------------------------------------------------------------
module fb_oled_reader
   import fb_oled_reader_pkg::*;
#(
   parameter int C_IMG_COLS     = 160,
   parameter int C_IMG_ROWS     = 120,
   parameter int C_NB_IMG_PXLS  = 15,
   parameter int C_NB_BUF_RED   = C_NB_BUF_RED_DEF,
   parameter int C_NB_BUF_GREEN = C_NB_BUF_GREEN_DEF,
   parameter int C_NB_BUF_BLUE  = C_NB_BUF_BLUE_DEF,
   parameter int C_OUT_COLS     = 128,
   parameter int C_OUT_ROWS     = 128,
   parameter int C_COLOR_BITS   = 8,
   parameter int C_SCALE_LOG2   = 0
) (
   input  logic            clk,
   input  logic            rst,
   fb_oled_reader_if.slave bus
);

   generate
      if (!(C_COLOR_BITS == 8 || C_COLOR_BITS == 16)) begin : g_bad_color_bits
         $error("fb_oled_reader: C_COLOR_BITS must be 8 or 16");
      end
      if (C_SCALE_LOG2 < 0 || C_SCALE_LOG2 > 2) begin : g_bad_scale
         $error("fb_oled_reader: C_SCALE_LOG2 must be 0..2");
      end
      if (C_NB_BUF_RED != 4 || C_NB_BUF_GREEN != 4 || C_NB_BUF_BLUE != 4) begin : g_bad_buf
         $error("fb_oled_reader: only 4-4-4 buffer words are supported");
      end
   endgenerate

   state_t                   state_q;
   logic [6:0]               x_q;
   logic [6:0]               y_q;
   logic [C_COLOR_BITS-1:0]  color_q;
   logic                     frame_start_q;
   logic                     overrun_q;

   logic                     adv;
   logic                     x_last;
   logic                     y_last;
   logic                     load;
   logic                     step_col;
   logic                     step_row;
   logic                     in_img;
   logic [C_NB_IMG_PXLS-1:0] fb_addr;
   buf_word_t                pix_src;

   assign adv      = (state_q == ST_READY) && bus.next_pixel;
   assign x_last   = (x_q == 7'(C_OUT_COLS - 1));
   assign y_last   = (y_q == 7'(C_OUT_ROWS - 1));
   assign load     = (state_q == ST_PRIME) || (adv && x_last && y_last);
   assign step_row = adv && x_last && !y_last;
   assign step_col = adv && !x_last;

   fb_oled_reader_fb_addr_gen #(
      .C_IMG_COLS    (C_IMG_COLS),
      .C_IMG_ROWS    (C_IMG_ROWS),
      .C_NB_IMG_PXLS (C_NB_IMG_PXLS),
      .C_SCALE_LOG2  (C_SCALE_LOG2)
   ) u_addr_gen (
      .clk        (clk),
      .rst        (rst),
      .load_i     (load),
      .step_col_i (step_col),
      .step_row_i (step_row),
      .off_col_i  (bus.off_col),
      .off_row_i  (bus.off_row),
      .fb_addr_o  (fb_addr),
      .in_img_o   (in_img)
   );

   // Source word for the colour register; black when outside the image.
   always_comb begin
      pix_src = in_img ? bus.fb_pxl : '0;
`ifdef FB_OLED_READER_TEST_PATTERN_EN
      if (bus.test_mode) begin
         pix_src = bar_pixel(x_q[6:4]);
      end
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= ST_PRIME;
         x_q           <= '0;
         y_q           <= '0;
         color_q       <= '0;
         frame_start_q <= 1'b0;
         overrun_q     <= 1'b0;
      end else begin
         frame_start_q <= 1'b0;
         if (bus.next_pixel && (state_q != ST_READY)) begin
            overrun_q <= 1'b1;
         end
         case (state_q)
            ST_PRIME: state_q <= ST_FETCH;
            ST_FETCH: state_q <= ST_LATCH;
            ST_LATCH: begin
               color_q <= C_COLOR_BITS'(pack_pixel(pix_src, C_COLOR_BITS));
               state_q <= ST_READY;
            end
            ST_READY: begin
               if (bus.next_pixel) begin
                  state_q <= ST_FETCH;
                  if (x_last) begin
                     x_q <= '0;
                     if (y_last) begin
                        y_q           <= '0;
                        frame_start_q <= 1'b1;
                     end else begin
                        y_q <= y_q + 7'd1;
                     end
                  end else begin
                     x_q <= x_q + 7'd1;
                  end
               end
            end
            default: state_q <= ST_PRIME;
         endcase
      end
   end

   assign bus.fb_addr     = fb_addr;
   assign bus.color       = color_q;
   assign bus.x           = x_q;
   assign bus.y           = y_q;
   assign bus.frame_start = frame_start_q;
   assign bus.overrun     = overrun_q;

endmodule
